issue_sequencer: RTL and testbench
==================================

# issue_sequencer

Sequences decoded 32-bit instructions into the single-issue ALU datapath and owns the register-write scoreboard, holding any instruction whose source registers are still in flight. Sits between the instruction source (fetch/test driver) and the decode/ALU/register-file datapath. It issues at most one instruction per cycle. It tracks each issued write through a fixed-latency pipeline and presents the write-back strobe to the register file.

## Interface
- LAT, 3: ALU result latency in cycles from issue to write-back (legal 1–8)
- SB_W, 16: width of the saturating stall counter
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_instr  in  32  instruction word
- in_ready  out  1  sequencer accepts in_instr this cycle
- flush  in  1  discard held, un-issued instruction
- iss_valid  out  1  instruction presented to datapath
- iss_instr  out  32  instruction being issued
- iss_ready  in  1  datapath accepts issue
- wb_en  out  1  register-file write strobe
- wb_rd  out  6  destination register for wb_en
- stall_cnt  out  SB_W  hazard-stall cycles, saturating
- busy  out  1  hold register or any scoreboard stage valid

## Operation
- Field decode, shared with decode unit: bit31 = imm_sel, [30:25] RS, [24:19] RD, [18:15] op, [14:9] RT.
- Instruction 32'd0 is a NOP: no sources, no destination, always issuable. It enters the pipe as an invalid stage.
- Sources:
  - op 4'b1011 or 4'b1001 (swapped forms): RS and RD.
  - Otherwise: RS, plus RT when imm_sel = 0.
- Destination: RD for every non-NOP instruction.
- One-entry hold register H (valid, instr). in_ready = !H.valid || issue_fire, where issue_fire = iss_valid && iss_ready.
- iss_valid = H.valid && !hazard && state == RUN.
- hazard = any live source equals rd of any valid scoreboard stage in the checked set (see Configuration).
- Scoreboard: LAT-stage shift pipe of (valid, rd). It advances every cycle. Stage 0 loads (issue_fire && non-NOP, RD). wb_en/wb_rd come from stage LAT-1.
- FSM:
  - RUN: normal. Goes to STALL when H.valid && hazard.
  - STALL: iss_valid = 0; stall_cnt increments each cycle, saturating at all-ones. Returns to RUN in the cycle hazard clears.
  - DRAIN: entered on flush. Hold register is cleared, in_ready = 0, and the scoreboard keeps advancing. Returns to RUN when all stages are invalid.
- flush and an accept in the same cycle: flush wins; the incoming word is dropped (in_ready is 0 while flush is high).
- A stalled H whose hazard is on stage LAT-1 frees on the following cycle.
- iss_instr = H.instr, held stable while iss_valid && !iss_ready.

## Timing
- Reset values:
  - in_ready 0 during rst, 1 the cycle after.
  - iss_valid 0, iss_instr 0, wb_en 0, wb_rd 0, stall_cnt 0, busy 0.
  - State RUN; all stages invalid.
- Accept-to-issue latency: 1 cycle minimum. Word accepted at edge N gives iss_valid high in cycle N+1.
- Issue-to-writeback latency: wb_en is high exactly LAT cycles after the issue_fire edge.
- Back-to-back independent instructions sustain 1 issue/cycle.
- A dependent instruction issues in the cycle after the producer's last checked stage.
- Reset mid-operation clears H, the pipe and stall_cnt. No wb_en fires for instructions in flight.

## Configuration
- ISSUE_FWD_EN defined: the datapath forwards the final stage, so stage LAT-1 is excluded from the hazard check. A dependent instruction may issue concurrently with the producer's wb_en.
- Not defined: all LAT stages are checked. The dependent instruction issues the cycle after wb_en.

## Structure
- Package issue_pkg holds:
  - Field bit-position constants.
  - OP_SWAP_A = 4'b1011 and OP_SWAP_B = 4'b1001.
  - NOP_WORD = 32'd0.
  - FSM state enum {RUN, STALL, DRAIN}.
- Sub-module issue_scoreboard: LAT-deep (valid, rd) pipe plus three-source match logic. Outputs hazard and the writeback pair.

## Test plan
- Reset then offer 0x00080000 (RD=1, op=0, imm_sel=0) with iss_ready=1: iss_valid in cycle 1, then wb_en with wb_rd=1 exactly LAT cycles after issue.
- Producer RD=5 followed by consumer RS=5: consumer is held.
  - With ISSUE_FWD_EN off: issues LAT cycles after the producer; stall_cnt = LAT-1.
  - With ISSUE_FWD_EN on: issues one cycle earlier; stall_cnt = LAT-2.
- Swap op 4'b1011 with RD=7 while reg 7 is in flight: stalls. The same word with op 4'b0000 and RT=7, imm_sel=1 does not stall.
- Stream of five 32'd0 words: five consecutive issues, no wb_en, busy drops one cycle after the last issue.
- Assert flush while H is stalled: H is dropped, in_ready stays 0 until the pipe empties, then returns to 1; pending wb_en still fires.
- Hold iss_ready=0 for 4 cycles: iss_instr is stable, in_ready=0, and stall_cnt is unchanged (backpressure is not counted as a hazard stall).

Source files
------------

// File: rtl/issue_pkg.sv
// issue_pkg: shared instruction field layout, special opcodes and sequencer
// state encoding for the issue sequencer and its scoreboard.
package issue_pkg;

    // Instruction field positions, shared with the decode unit
    localparam int IMM_BIT = 31;
    localparam int RS_HI   = 30;
    localparam int RS_LO   = 25;
    localparam int RD_HI   = 24;
    localparam int RD_LO   = 19;
    localparam int OP_HI   = 18;
    localparam int OP_LO   = 15;
    localparam int RT_HI   = 14;
    localparam int RT_LO   = 9;

    // Swapped-operand forms read RD as their second source instead of RT
    localparam logic [3:0] OP_SWAP_A = 4'b1011;
    localparam logic [3:0] OP_SWAP_B = 4'b1001;

    // The all-zero word reads nothing and writes nothing
    localparam logic [31:0] NOP_WORD = 32'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // Up to three candidate source registers, each with its own live flag
    typedef struct packed {
        logic       rsLive;
        logic       rtLive;
        logic       rdLive;
        logic [5:0] rs;
        logic [5:0] rt;
        logic [5:0] rd;
    } src_set_t;

    // Work out which register fields an instruction actually reads
    function automatic src_set_t decodeSources(input logic [31:0] instr);
        src_set_t s;
        logic     isNop;
        logic     isSwap;
        isNop    = (instr == NOP_WORD);
        isSwap   = (instr[OP_HI:OP_LO] == OP_SWAP_A) || (instr[OP_HI:OP_LO] == OP_SWAP_B);
        s.rs     = instr[RS_HI:RS_LO];
        s.rt     = instr[RT_HI:RT_LO];
        s.rd     = instr[RD_HI:RD_LO];
        s.rsLive = !isNop;
        s.rdLive = !isNop && isSwap;
        s.rtLive = !isNop && !isSwap && !instr[IMM_BIT];
        return s;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: LAT-deep (valid, rd) pipe tracking issued register writes,
// with the source-match logic that reports a read-after-write hazard.
// Build option: ISSUE_FWD_EN excludes the final stage from the hazard check
// because the datapath forwards that result.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [5:0] i_loadRd,
    input  src_set_t   i_srcs,
    output logic       o_hazard,
    output logic       o_wbEn,
    output logic [5:0] o_wbRd,
    output logic       o_anyValid
);

`ifdef ISSUE_FWD_EN
    localparam int CHECK_N = LAT - 1;
`else
    localparam int CHECK_N = LAT;
`endif

    logic [LAT-1:0] r_valid;
    logic [5:0]     r_rd [LAT];
    logic           w_hazard;

    // Shift every stage down one place each cycle; stage 0 takes the new write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_rd[k] <= 6'd0;
            end
        end else begin
            r_valid[0] <= i_load;
            r_rd[0]    <= i_loadRd;
            for (int k = 1; k < LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
        end
    end

    // Any live source matching a pending destination in the checked stages blocks issue
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < CHECK_N; k++) begin
            if (r_valid[k]) begin
                if ((i_srcs.rsLive && (i_srcs.rs == r_rd[k])) ||
                    (i_srcs.rtLive && (i_srcs.rt == r_rd[k])) ||
                    (i_srcs.rdLive && (i_srcs.rd == r_rd[k]))) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    assign o_hazard   = w_hazard;
    assign o_wbEn     = r_valid[LAT-1] && !rst;
    assign o_wbRd     = o_wbEn ? r_rd[LAT-1] : 6'd0;
    assign o_anyValid = |r_valid;

endmodule

// File: rtl/issue_sequencer.sv
// issue_sequencer: holds one decoded instruction, issues it to the ALU datapath
// once its sources are clear of the write scoreboard, and drives write-back.
// Build option: ISSUE_FWD_EN (final-stage forwarding, applied in issue_scoreboard).
module issue_sequencer
    import issue_pkg::*;
#(
    parameter int LAT  = 3,
    parameter int SB_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    input  logic            flush,
    output logic            iss_valid,
    output logic [31:0]     iss_instr,
    input  logic            iss_ready,
    output logic            wb_en,
    output logic [5:0]      wb_rd,
    output logic [SB_W-1:0] stall_cnt,
    output logic            busy
);

    logic            r_hValid;
    logic [31:0]     r_hInstr;
    seq_state_e      r_state;
    seq_state_e      w_nextState;
    logic [SB_W-1:0] r_stallCnt;
    src_set_t        w_srcs;
    logic            w_hazard;
    logic            w_anyValid;
    logic            w_issValid;
    logic            w_inReady;
    logic            w_fire;
    logic            w_accept;
    logic            w_load;
    logic            w_wbEn;
    logic [5:0]      w_wbRd;

    // Sources of the held word; an empty hold register reads nothing
    always_comb begin
        w_srcs        = decodeSources(r_hInstr);
        w_srcs.rsLive = w_srcs.rsLive && r_hValid;
        w_srcs.rtLive = w_srcs.rtLive && r_hValid;
        w_srcs.rdLive = w_srcs.rdLive && r_hValid;
    end

    // A STALL releases in the very cycle its hazard clears, so only DRAIN blocks issue outright
    assign w_issValid = !rst && r_hValid && !w_hazard && (r_state != DRAIN);
    assign w_fire     = w_issValid && iss_ready;
    assign w_inReady  = !rst && !flush && (r_state != DRAIN) && (!r_hValid || w_fire);
    assign w_accept   = in_valid && w_inReady;
    assign w_load     = w_fire && (r_hInstr != NOP_WORD);

    issue_scoreboard #(
        .LAT(LAT)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_loadRd  (r_hInstr[RD_HI:RD_LO]),
        .i_srcs    (w_srcs),
        .o_hazard  (w_hazard),
        .o_wbEn    (w_wbEn),
        .o_wbRd    (w_wbRd),
        .o_anyValid(w_anyValid)
    );

    // Hold register: flush discards it, an accept refills it, an issue empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hValid <= 1'b0;
            r_hInstr <= 32'd0;
        end else if (flush) begin
            r_hValid <= 1'b0;
            r_hInstr <= 32'd0;
        end else if (w_accept) begin
            r_hValid <= 1'b1;
            r_hInstr <= in_instr;
        end else if (w_fire) begin
            r_hValid <= 1'b0;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: hazards park us in STALL, flush drains the scoreboard before resuming
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN: begin
                if (flush) begin
                    w_nextState = DRAIN;
                end else if (r_hValid && w_hazard) begin
                    w_nextState = STALL;
                end
            end
            STALL: begin
                if (flush) begin
                    w_nextState = DRAIN;
                end else if (!w_hazard) begin
                    w_nextState = RUN;
                end
            end
            DRAIN: begin
                if (!flush && !w_anyValid) begin
                    w_nextState = RUN;
                end
            end
            default: w_nextState = RUN;
        endcase
    end

    // Count cycles spent blocked by a hazard, saturating; backpressure is not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if ((r_state == STALL) && w_hazard && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + SB_W'(1);
        end
    end

    assign in_ready  = w_inReady;
    assign iss_valid = w_issValid;
    assign iss_instr = r_hInstr;
    assign wb_en     = w_wbEn;
    assign wb_rd     = w_wbRd;
    assign stall_cnt = r_stallCnt;
    assign busy      = r_hValid || w_anyValid;

endmodule

// File: tb/tb_issue_sequencer.sv
// tb_issue_sequencer: directed stimulus for issue_sequencer, checked every cycle
// against a queue-based model of in-flight writes plus literal expectations.
// Honours ISSUE_FWD_EN the same way the design does.
module tb_issue_sequencer;

    localparam int LAT  = 3;
    localparam int SB_W = 3;
    localparam int SAT  = (1 << SB_W) - 1;
`ifdef ISSUE_FWD_EN
    localparam int CHK       = LAT - 1;
    localparam int DEP_OFF   = LAT - 1;
    localparam int DEP_STALL = LAT - 2;
`else
    localparam int CHK       = LAT;
    localparam int DEP_OFF   = LAT;
    localparam int DEP_STALL = LAT - 1;
`endif
    localparam int EXP_AFTER3 = 2 * DEP_STALL;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic            flush;
    logic            iss_valid;
    logic [31:0]     iss_instr;
    logic            iss_ready;
    logic            wb_en;
    logic [5:0]      wb_rd;
    logic [SB_W-1:0] stall_cnt;
    logic            busy;

    int total = 0;
    int bad   = 0;

    issue_sequencer #(
        .LAT (LAT),
        .SB_W(SB_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .flush    (flush),
        .iss_valid(iss_valid),
        .iss_instr(iss_instr),
        .iss_ready(iss_ready),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .stall_cnt(stall_cnt),
        .busy     (busy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkInstr(input logic imm, input logic [5:0] rs, input logic [5:0] rd,
                                            input logic [3:0] op, input logic [5:0] rt);
        return {imm, rs, rd, op, rt, 9'd0};
    endfunction

    // Does this instruction read register r?
    function automatic bit usesReg(input logic [31:0] ins, input int r);
        logic [3:0] op;
        if (ins == 32'd0) return 1'b0;
        op = ins[18:15];
        if (int'(ins[30:25]) == r) return 1'b1;
        if (op == 4'b1011 || op == 4'b1001) return int'(ins[24:19]) == r;
        if (!ins[31]) return int'(ins[14:9]) == r;
        return 1'b0;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int rd;
        int age;
    } flight_t;

    flight_t     fq[$];
    bit          mHV;
    logic [31:0] mI;
    bit          mDrain;
    bit          mStalled;
    int          mStall;

    bit          eHaz;
    bit          eIss;
    bit          eFire;
    bit          eInR;
    bit          eWb;
    int          eWbRd;
    bit          eBusy;
    flight_t     fe;

    // Compare the DUT against the model each cycle, then advance the model
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("m_rst_in_ready", 32'(in_ready), 0);
            checkOutput("m_rst_iss_valid", 32'(iss_valid), 0);
            checkOutput("m_rst_wb_en", 32'(wb_en), 0);
            fq.delete();
            mHV = 0; mI = 32'd0; mDrain = 0; mStalled = 0; mStall = 0;
        end else begin
            eHaz = 0;
            eWb = 0;
            eWbRd = 0;
            foreach (fq[i]) begin
                if (mHV && fq[i].age <= CHK && usesReg(mI, fq[i].rd)) eHaz = 1;
                if (fq[i].age == LAT) begin
                    eWb = 1;
                    eWbRd = fq[i].rd;
                end
            end
            eIss  = mHV && !eHaz && !mDrain;
            eFire = eIss && iss_ready;
            eInR  = !mDrain && !flush && (!mHV || eFire);
            eBusy = mHV || (fq.size() > 0);

            checkOutput("m_iss_valid", 32'(iss_valid), 32'(eIss));
            checkOutput("m_iss_instr", iss_instr, mI);
            checkOutput("m_in_ready", 32'(in_ready), 32'(eInR));
            checkOutput("m_wb_en", 32'(wb_en), 32'(eWb));
            checkOutput("m_wb_rd", 32'(wb_rd), eWbRd);
            checkOutput("m_stall_cnt", 32'(stall_cnt), mStall);
            checkOutput("m_busy", 32'(busy), 32'(eBusy));

            if (mStalled && eHaz && mStall < SAT) mStall++;
            mStalled = !flush && !mDrain && mHV && eHaz;

            if (flush) mDrain = 1;
            else if (mDrain && fq.size() == 0) mDrain = 0;

            for (int i = 0; i < fq.size(); i++) begin
                fe = fq[i];
                fe.age++;
                fq[i] = fe;
            end
            while (fq.size() > 0 && fq[0].age > LAT) void'(fq.pop_front());
            if (eFire && mI != 32'd0) begin
                fe.rd = int'(mI[24:19]);
                fe.age = 1;
                fq.push_back(fe);
            end

            if (flush) begin
                mHV = 0;
                mI = 32'd0;
            end else if (in_valid && eInR) begin
                mHV = 1;
                mI = in_instr;
            end else if (eFire) begin
                mHV = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = v;
        in_instr  = ins;
        iss_ready = rdy;
        flush     = fl;
        @(negedge clk);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; iss_ready = 1'b1; flush = 1'b0;
            @(negedge clk);
            checkOutput("rst_in_ready_low", 32'(in_ready), 0);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        while (busy !== 1'b0 && n < 40) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 40) checkOutput("idle_timeout", 32'(busy), 0);
    endtask

    // Producer writes r, consumer reads r; returns cycles from consumer landing in H to its issue
    task automatic depPair(input logic [5:0] r, output int idx);
        logic [31:0] p;
        logic [31:0] c;
        p = mkInstr(1'b0, 6'd2, r, 4'd0, 6'd3);
        c = mkInstr(1'b1, r, r + 6'd1, 4'd0, 6'd0);
        applyStimulus(1'b1, p, 1'b1, 1'b0);
        applyStimulus(1'b1, c, 1'b1, 1'b0);
        checkOutput("dep_producer_issue", 32'(iss_valid), 1);
        checkOutput("dep_consumer_accept", 32'(in_ready), 1);
        idx = -1;
        for (int k = 0; k < 20 && idx < 0; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
            if (iss_valid === 1'b1) begin
                idx = k;
                checkOutput("dep_consumer_instr", iss_instr, c);
            end
        end
    endtask

    initial begin
        int idx;
        logic [31:0] w;
        logic [31:0] s;
        logic [31:0] x;
        logic [31:0] y;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; iss_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        doReset(2);

        // Single instruction: issue one cycle after accept, write-back LAT cycles after issue
        applyStimulus(1'b1, 32'h0008_0000, 1'b1, 1'b0);
        checkOutput("t1_in_ready_after_rst", 32'(in_ready), 1);
        checkOutput("t1_iss_valid_c0", 32'(iss_valid), 0);
        checkOutput("t1_busy_c0", 32'(busy), 0);
        checkOutput("t1_stall_c0", 32'(stall_cnt), 0);
        checkOutput("t1_iss_instr_c0", iss_instr, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t1_iss_valid_c1", 32'(iss_valid), 1);
        checkOutput("t1_iss_instr_c1", iss_instr, 32'h0008_0000);
        for (int k = 2; k <= LAT + 1; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
            if (k == LAT + 1) begin
                checkOutput("t1_wb_en", 32'(wb_en), 1);
                checkOutput("t1_wb_rd", 32'(wb_rd), 1);
            end else begin
                checkOutput("t1_wb_early", 32'(wb_en), 0);
            end
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t1_busy_end", 32'(busy), 0);

        // RAW dependency through register 5
        depPair(6'd5, idx);
        checkOutput("t2_issue_offset", 32'(idx), DEP_OFF);
        checkOutput("t2_stall_cnt", 32'(stall_cnt), DEP_STALL);
        waitIdle();

        // Swap opcode reads RD: stalls on in-flight reg 7
        w = mkInstr(1'b1, 6'd1, 6'd7, 4'd0, 6'd0);
        s = mkInstr(1'b1, 6'd2, 6'd7, 4'b1011, 6'd0);
        applyStimulus(1'b1, w, 1'b1, 1'b0);
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t3_swap_stalls", 32'(iss_valid), 0);
        waitIdle();
        checkOutput("t3_stall_cnt", 32'(stall_cnt), EXP_AFTER3);
        // Plain op with imm_sel=1 ignores RT=7
        s = mkInstr(1'b1, 6'd2, 6'd7, 4'd0, 6'd7);
        applyStimulus(1'b1, w, 1'b1, 1'b0);
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t3_imm_no_stall", 32'(iss_valid), 1);
        checkOutput("t3_imm_instr", iss_instr, s);
        waitIdle();

        // Five NOPs back to back
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'd0, 1'b1, 1'b0);
            if (i > 0) checkOutput("t4_nop_issue", 32'(iss_valid), 1);
            checkOutput("t4_nop_no_wb", 32'(wb_en), 0);
        end
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t4_last_nop_issue", 32'(iss_valid), 1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t4_busy_drop", 32'(busy), 0);
        checkOutput("t4_no_wb", 32'(wb_en), 0);

        // Backpressure: held word stable, not counted as a stall
        x = mkInstr(1'b1, 6'd3, 6'd4, 4'd0, 6'd0);
        y = mkInstr(1'b1, 6'd5, 6'd6, 4'd0, 6'd0);
        applyStimulus(1'b1, x, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, y, 1'b0, 1'b0);
            checkOutput("t6_bp_valid", 32'(iss_valid), 1);
            checkOutput("t6_bp_instr", iss_instr, x);
            checkOutput("t6_bp_in_ready", 32'(in_ready), 0);
            checkOutput("t6_bp_stall", 32'(stall_cnt), EXP_AFTER3);
        end
        applyStimulus(1'b1, y, 1'b1, 1'b0);
        checkOutput("t6_release_ready", 32'(in_ready), 1);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t6_next_instr", iss_instr, y);
        waitIdle();

        // Flush a stalled hold register; the pending write still completes
        w = mkInstr(1'b0, 6'd1, 6'd9, 4'd0, 6'd1);
        s = mkInstr(1'b1, 6'd9, 6'd10, 4'd0, 6'd0);
        applyStimulus(1'b1, w, 1'b1, 1'b0);
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t5_held", 32'(iss_valid), 0);
        applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b1);
        checkOutput("t5_flush_in_ready", 32'(in_ready), 0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t5_drain_in_ready", 32'(in_ready), 0);
        checkOutput("t5_drain_wb_en", 32'(wb_en), 1);
        checkOutput("t5_drain_wb_rd", 32'(wb_rd), 9);
        checkOutput("t5_drain_no_issue", 32'(iss_valid), 0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t5_empty_in_ready", 32'(in_ready), 0);
        checkOutput("t5_empty_busy", 32'(busy), 0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t5_resume_in_ready", 32'(in_ready), 1);
        checkOutput("t5_stall_cnt", 32'(stall_cnt), EXP_AFTER3 + 1);

        // Repeated dependencies drive the counter into saturation
        for (int i = 0; i < 6; i++) begin
            depPair(6'(20 + i), idx);
            checkOutput("t8_issue_offset", 32'(idx), DEP_OFF);
            waitIdle();
        end
        checkOutput("t8_stall_saturated", 32'(stall_cnt), SAT);

        // Reset while a write is in flight: it never reaches write-back
        w = mkInstr(1'b1, 6'd1, 6'd12, 4'd0, 6'd0);
        applyStimulus(1'b1, w, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("t7_issue", 32'(iss_valid), 1);
        doReset(1);
        for (int k = 0; k <= LAT; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
            checkOutput("t7_no_wb", 32'(wb_en), 0);
            if (k == 0) begin
                checkOutput("t7_stall_cleared", 32'(stall_cnt), 0);
                checkOutput("t7_busy_cleared", 32'(busy), 0);
                checkOutput("t7_in_ready", 32'(in_ready), 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound the whole run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
